// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: per-stage advance/stall/bubble/flush control for a 5-stage core.
// Latency: controls are combinational from registered state and current inputs (zero cycles).
// Backpressure: an unfinished data-memory access freezes the whole pipe; a long freeze traps.
module hazard_sequencer #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             pipe_write,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_TRAP = 2'b10;

  // Wide enough to hold MEM_TIMEOUT-1, the last count before trapping.
  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [WC_W-1:0] wait_cnt;
  logic            use1;
  logic            use2;
  logic            lu;
  logic            freeze;
  logic            timeout;

  // Which source registers the ID instruction really reads, by opcode class.
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      7'b0010011, 7'b0000011: begin
        use1 = 1'b1;
      end
      default: begin
        use1 = 1'b0;
        use2 = 1'b0;
      end
    endcase
  end

  // Hazard conditions; x0 is never a real dependency.
  always_comb begin
    lu = ex_mem_read && (ex_rd != '0) &&
         ((use1 && (id_rs1 == ex_rd)) || (use2 && (id_rs2 == ex_rd)));
    freeze  = mem_req && !mem_ready;
    timeout = freeze && (wait_cnt == WC_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a long freeze traps, any unfrozen cycle returns to RUN, TRAP is absorbing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (timeout) begin
          state_d = ST_TRAP;
        end else if (freeze) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_TRAP;
    endcase
  end

  // Stage controls: TRAP > freeze > branch flush > load-use stall > normal advance.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    pipe_write    = 1'b1;
    id_ex_bubble  = 1'b0;
    flush         = 1'b0;
    mem_wb_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_write  = 1'b0;
    end else if (state_q == ST_TRAP || freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_write    = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (mem_branch_taken) begin
      // The ID instruction is flushed, so a coincident load-use needs no bubble.
      flush = 1'b1;
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Consecutive frozen-cycle counter, counting from the first frozen cycle in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_q != ST_TRAP) begin
      if (freeze) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Saturating performance counters; TRAP cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write && state_q != ST_TRAP && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush && flush_events != '1) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end

  assign state = state_q;
  assign trap  = (state_q == ST_TRAP);

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with MEM_TIMEOUT=4 and CNT_W=4.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Every expected value is hand-computed from the specified behaviour.
module tb_hazard_sequencer;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       id_opcode;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             mem_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             pipe_write;
  logic             id_ex_bubble;
  logic             flush;
  logic             mem_wb_bubble;
  logic [1:0]       state;
  logic             trap;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  hazard_sequencer #(.REG_W(REG_W), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .pipe_write(pipe_write),
    .id_ex_bubble(id_ex_bubble), .flush(flush), .mem_wb_bubble(mem_wb_bubble),
    .state(state), .trap(trap), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_opcode = 7'd0; id_rs1 = '0; id_rs2 = '0;
    ex_mem_read = 1'b0; ex_rd = '0;
    mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ld, input logic [4:0] rd);
    id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; ex_mem_read = ld; ex_rd = rd;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    // Reset: controls held at zero, registers cleared after an edge.
    next_cycle(); #1;
    check("rst_pc", pc_write, 0);
    check("rst_ifid", if_id_write, 0);
    check("rst_pipe", pipe_write, 0);
    check("rst_mwb", mem_wb_bubble, 0);
    check("rst_flush", flush, 0);
    next_cycle(); #1;
    check("rst_state", state, 0);
    check("rst_trap", trap, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_flev", flush_events, 0);
    reset = 1'b0;

    // Load x5 in EX, add x6,x5,x1 in ID: one bubble.
    next_cycle(); set_lu(OP_R, 5'd5, 5'd1, 1'b1, 5'd5); #1;
    check("lu_pc", pc_write, 0);
    check("lu_ifid", if_id_write, 0);
    check("lu_pipe", pipe_write, 1);
    check("lu_bubble", id_ex_bubble, 1);
    next_cycle(); ex_mem_read = 1'b0; #1;
    check("lu_after_pc", pc_write, 1);
    check("lu_after_ifid", if_id_write, 1);
    check("lu_after_bubble", id_ex_bubble, 0);
    check("lu_stall_cnt", stall_cycles, 1);

    // Store uses rs2: match on rs2 stalls.
    next_cycle(); set_lu(OP_S, 5'd1, 5'd5, 1'b1, 5'd5); #1;
    check("lu_rs2_bubble", id_ex_bubble, 1);
    check("lu_rs2_pc", pc_write, 0);

    // I-type ignores rs2; x0 destination never stalls; LUI reads nothing.
    next_cycle(); set_lu(OP_I, 5'd0, 5'd5, 1'b1, 5'd5); #1;
    check("itype_pc", pc_write, 1);
    check("itype_bubble", id_ex_bubble, 0);
    check("lu_stall_cnt2", stall_cycles, 2);
    next_cycle(); set_lu(OP_R, 5'd0, 5'd0, 1'b1, 5'd0); #1;
    check("x0_pc", pc_write, 1);
    next_cycle(); set_lu(OP_LUI, 5'd5, 5'd5, 1'b1, 5'd5); #1;
    check("lui_pc", pc_write, 1);

    // Three frozen cycles then ready.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); clear_inputs(); mem_req = 1'b1; #1;
      check("frz_mwb", mem_wb_bubble, 1);
      check("frz_pc", pc_write, 0);
      check("frz_pipe", pipe_write, 0);
      check("frz_state", state, (i == 0) ? 0 : 1);
    end
    next_cycle(); mem_ready = 1'b1; #1;
    check("rdy_pc", pc_write, 1);
    check("rdy_pipe", pipe_write, 1);
    check("rdy_mwb", mem_wb_bubble, 0);
    check("rdy_state", state, 1);
    next_cycle(); clear_inputs(); #1;
    check("frz_back_run", state, 0);
    check("frz_stall_cnt", stall_cycles, 5);
    check("frz_trap", trap, 0);

    // Branch held through a 2-cycle freeze; flush only on the ready cycle, load-use discarded.
    for (int i = 0; i < 2; i++) begin
      next_cycle(); mem_req = 1'b1; mem_branch_taken = 1'b1; #1;
      check("brfrz_flush", flush, 0);
      check("brfrz_mwb", mem_wb_bubble, 1);
    end
    next_cycle(); mem_ready = 1'b1; set_lu(OP_R, 5'd5, 5'd1, 1'b1, 5'd5); #1;
    check("br_flush", flush, 1);
    check("br_bubble", id_ex_bubble, 0);
    check("br_pc", pc_write, 1);
    next_cycle(); clear_inputs(); #1;
    check("br_flush_off", flush, 0);
    check("br_flev", flush_events, 1);
    check("br_stall_cnt", stall_cycles, 7);

    // mem_req dropped mid-wait: back to RUN, wait count cleared.
    for (int i = 0; i < 2; i++) begin
      next_cycle(); mem_req = 1'b1; #1;
    end
    next_cycle(); mem_req = 1'b0; #1;
    check("drop_state", state, 1);
    check("drop_pc", pc_write, 1);
    check("drop_mwb", mem_wb_bubble, 0);

    // Timeout: four consecutive frozen cycles trap (would trap early if count not cleared).
    for (int i = 0; i < 4; i++) begin
      next_cycle(); mem_req = 1'b1; #1;
      check("to_state", state, (i == 0) ? 0 : 1);
      check("to_trap", trap, 0);
    end
    next_cycle(); #1;
    check("trap_state", state, 2);
    check("trap_flag", trap, 1);
    check("trap_pc", pc_write, 0);
    check("trap_mwb", mem_wb_bubble, 1);
    check("trap_stall_cnt", stall_cycles, 13);
    next_cycle(); mem_req = 1'b0; mem_ready = 1'b1; mem_branch_taken = 1'b1; #1;
    check("trap_hold_pc", pc_write, 0);
    check("trap_hold_flush", flush, 0);
    check("trap_hold_mwb", mem_wb_bubble, 1);
    next_cycle(); #1;
    check("trap_hold_state", state, 2);
    check("trap_no_stall_cnt", stall_cycles, 13);
    check("trap_flev", flush_events, 1);

    // Reset from TRAP.
    reset = 1'b1; #1;
    check("trst_pc", pc_write, 0);
    check("trst_mwb", mem_wb_bubble, 0);
    check("trst_flush", flush, 0);
    next_cycle(); reset = 1'b0; clear_inputs(); #1;
    check("trst_state", state, 0);
    check("trst_trap", trap, 0);
    check("trst_stall", stall_cycles, 0);
    check("trst_flev", flush_events, 0);
    check("trst_run_pc", pc_write, 1);

    // Saturation: 20 stall cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      next_cycle(); set_lu(OP_R, 5'd7, 5'd2, 1'b1, 5'd7); #1;
      if (i == 14) check("sat_mid", stall_cycles, 14);
    end
    next_cycle(); clear_inputs(); #1;
    check("sat_full", stall_cycles, 15);
    check("sat_pc", pc_write, 1);
    next_cycle(); #1;
    check("sat_hold", stall_cycles, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
